hex_display_bank: RTL and testbench

Parametrised multi-digit seven-segment driver for the DE-board lab top level. It generalises the single-digit switch-to-HEX decoder to NUM_DIGITS digits. It holds a loadable value that can optionally free-run as a counter on a prescaled tick, and it supports leading-zero blanking and display blinking. It sits between the switch/control logic and the HEX0..HEXn and LEDR pins.

---
 rtl/hex_display_pkg.sv | 36 +++
 rtl/hex_display_bank_decoder.sv | 12 +
 rtl/hex_display_bank.sv | 94 +++++++++
 tb/tb_hex_display_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared widths, the blank pattern and the active-low seven-segment table
// used by the hex display bank and its per-digit decoder.
package hex_display_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Segment order is g..a (bit 6 = g, bit 0 = a), active low.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIBBLE_W-1:0] nibble);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_bank_decoder.sv
// Combinational single-digit decoder: one hex nibble to active-low
// seven-segment pattern.
module hex_digit_decoder
    import hex_display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    segments
);

    assign segments = seg_decode(nibble);

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: loadable/counting held value, tick
// prescaler, blink phase, leading-zero blanking and registered segment outputs.
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                           input_clock_50,
    input  logic                           input_reset,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] input_value,
    input  logic                           input_load,
    input  logic                           input_count_enable,
    input  logic                           input_blink_enable,
    input  logic                           input_blank_zeros,
    output logic [SEG_W*NUM_DIGITS-1:0]    output_hex,
    output logic [NIBBLE_W*NUM_DIGITS-1:0] output_LEDR,
    output logic                           output_tick
);

    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]                   prescaler;
    logic                               tick;
    logic                               blink_phase;
    logic [VAL_W-1:0]                   held;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]   dec_seg;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]   hex_next;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]   hex_reg;
    logic                               all_zero;

    assign tick = (prescaler == CNT_LAST);

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // reset in the sensitivity list, so reset clears them without a clock edge.
    always_ff @(posedge input_clock_50 or posedge input_reset) begin
        if (input_reset) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + CNT_W'(1);
            if (tick)
                blink_phase <= ~blink_phase;
        end
    end

    // Load wins over a coincident counting tick; all-F wraps to zero silently.
    always_ff @(posedge input_clock_50 or posedge input_reset) begin
        if (input_reset)
            held <= '0;
        else if (input_load)
            held <= input_value;
        else if (tick && input_count_enable)
            held <= held + VAL_W'(1);
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_digit_decoder u_dec (
            .nibble   (held[g*NIBBLE_W +: NIBBLE_W]),
            .segments (dec_seg[g])
        );
    end

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hex_next = '0;
        all_zero = 1'b1;
        // Walk from the most significant digit down, tracking "all zero so far".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (held[i*NIBBLE_W +: NIBBLE_W] == '0);
            if (input_blink_enable && blink_phase)
                hex_next[i] = SEG_BLANK;
            else if (input_blank_zeros && (i != 0) && all_zero)
                hex_next[i] = SEG_BLANK;
            else
                hex_next[i] = dec_seg[i];
        end
    end

    always_ff @(posedge input_clock_50 or posedge input_reset) begin
        if (input_reset)
            hex_reg <= {NUM_DIGITS{SEG_BLANK}};
        else
            hex_reg <= hex_next;
    end

    assign output_hex  = hex_reg;
    assign output_LEDR = held;
    assign output_tick = tick;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with NUM_DIGITS=4, TICK_DIV=4:
// reset, tick cadence, load/decode, wrap, load-vs-tick, blink and async reset.
module tb_hex_display_bank;

    localparam int NUM_DIGITS = 4;
    localparam int TICK_DIV   = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        count_enable;
    logic        blink_enable;
    logic        blank_zeros;
    logic [27:0] hex;
    logic [15:0] ledr;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    hex_display_bank #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .input_clock_50     (clk),
        .input_reset        (rst),
        .input_value        (value),
        .input_load         (load),
        .input_count_enable (count_enable),
        .input_blink_enable (blink_enable),
        .input_blank_zeros  (blank_zeros),
        .output_hex         (hex),
        .output_LEDR        (ledr),
        .output_tick        (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        value        = '0;
        load         = 1'b0;
        count_enable = 1'b0;
        blink_enable = 1'b0;
        blank_zeros  = 1'b0;

        @(negedge clk);
        check("reset_ledr", 32'(ledr), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_hex",  32'(hex),  32'h0FFF_FFFF);

        @(negedge clk);
        rst   = 1'b0;
        edges = 0;

        // Tick pulses in cycles 4, 8, 12 after release.
        for (int k = 1; k <= 12; k++) begin
            step();
            check("idle_tick", 32'(tick), 32'(edges % 4 == 3));
            if (k == 1) begin
                check("idle_ledr", 32'(ledr), 32'h0);
                check("idle_hex_zeros", 32'(hex), 32'({S0, S0, S0, S0}));
                blank_zeros = 1'b1;
            end
            if (k == 2)
                check("idle_hex_blanked", 32'(hex), 32'({BL, BL, BL, S0}));
        end
        blank_zeros = 1'b0;

        // Load 0xA5F0: LEDR after one edge, segments after two.
        value = 16'hA5F0;
        load  = 1'b1;
        step();
        check("load_a5f0_ledr", 32'(ledr), 32'hA5F0);
        load = 1'b0;
        step();
        check("load_a5f0_hex", 32'(hex), 32'({SA, S5, SF, S0}));

        // Load 0xFFFE with counting; two ticks wrap to zero.
        value        = 16'hFFFE;
        load         = 1'b1;
        count_enable = 1'b1;
        step();
        check("fffe_ledr", 32'(ledr), 32'hFFFE);
        check("fffe_tick", 32'(tick), 32'h1);
        load = 1'b0;
        step();
        check("tick1_ffff", 32'(ledr), 32'hFFFF);
        step();
        step();
        step();
        check("pre_wrap_ffff", 32'(ledr), 32'hFFFF);
        check("pre_wrap_tick", 32'(tick), 32'h1);
        step();
        check("wrap_0000", 32'(ledr), 32'h0000);
        check("wrap_hex_ffff", 32'(hex), 32'({SF, SF, SF, SF}));

        // Load coincident with a tick: load wins, tick cadence unchanged.
        step();
        step();
        step();
        check("coinc_tick", 32'(tick), 32'h1);
        value = 16'h1234;
        load  = 1'b1;
        step();
        check("coinc_load_1234", 32'(ledr), 32'h1234);
        load = 1'b0;
        step();
        check("coinc_no_tick_a", 32'(tick), 32'h0);
        step();
        check("coinc_no_tick_b", 32'(tick), 32'h0);
        step();
        check("coinc_next_tick", 32'(tick), 32'h1);
        check("coinc_hold_1234", 32'(ledr), 32'h1234);
        step();
        check("coinc_inc_1235", 32'(ledr), 32'h1235);

        // Blink with held 0x0042: blank phase follows the tick-driven toggle.
        count_enable = 1'b0;
        value        = 16'h0042;
        load         = 1'b1;
        step();
        check("blink_load_ledr", 32'(ledr), 32'h0042);
        load         = 1'b0;
        blink_enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("blink_ledr", 32'(ledr), 32'h0042);
            if (((edges - 1) / 4) % 2 == 1)
                check("blink_hex_off", 32'(hex), 32'h0FFF_FFFF);
            else
                check("blink_hex_on", 32'(hex), 32'({S0, S0, S4, S2}));
        end
        blink_enable = 1'b0;

        // Asynchronous reset mid-count with held=0x0007, prescaler=2.
        value        = 16'h0007;
        load         = 1'b1;
        count_enable = 1'b1;
        step();
        load = 1'b0;
        check("pre_rst_ledr", 32'(ledr), 32'h0007);
        check("pre_rst_tick", 32'(tick), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_ledr", 32'(ledr), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_hex",  32'(hex),  32'h0FFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b0;
        count_enable = 1'b0;
        edges        = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("restart_tick", 32'(tick), 32'(edges % 4 == 3));
            if (k == 1) begin
                check("restart_ledr", 32'(ledr), 32'h0);
                check("restart_hex", 32'(hex), 32'({S0, S0, S0, S0}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
